// File: rtl/skencode_s1s2_pack_pkg.sv
// Shared ML-DSA parameters and the sk s1/s2 pack FSM state type.
// Contents: modulus/eta/poly-size constants, derived beat/word counts,
// and skencode_state_e used by skencode_s1s2_pack.
package skencode_s1s2_pack_pkg;

  localparam int REG_SIZE  = 24;
  localparam int MLDSA_ETA = 2;
  localparam int ETA_SIZE  = 3;
  localparam int MLDSA_Q   = 8380417;
  localparam int MLDSA_N   = 256;
  localparam int NUM_COEFF = 4;
  localparam int DATA_W    = 32;

  localparam int BEAT_BITS = NUM_COEFF * ETA_SIZE;           // 12
  localparam int BUF_W     = 48;
  localparam int NUM_BEATS = MLDSA_N / NUM_COEFF;            // 64
  localparam int NUM_WORDS = (MLDSA_N * ETA_SIZE) / DATA_W;  // 24

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PACK = 2'd1,
    DONE = 2'd2
  } skencode_state_e;

endpackage

// File: rtl/skencode_s1s2_coeff_enc.sv
// Combinational encoder for one s1/s2 coefficient: code = eta - coeff.
// Ports:
//   coeff  in  REG_SIZE  coefficient mod q, legal values {0,1,2,q-1,q-2}
//   code   out ETA_SIZE  packed value 0..4 (0 for illegal input)
//   err    out 1         coefficient outside [-eta, eta]
import skencode_s1s2_pack_pkg::*;

module skencode_s1s2_coeff_enc (
  input  logic [REG_SIZE-1:0] coeff,
  output logic [ETA_SIZE-1:0] code,
  output logic                err
);

  localparam logic [REG_SIZE-1:0] Q_M1 = REG_SIZE'(MLDSA_Q - 1);
  localparam logic [REG_SIZE-1:0] Q_M2 = REG_SIZE'(MLDSA_Q - 2);

  always_comb begin
    code = '0;
    err  = 1'b0;
    if (coeff == REG_SIZE'(2))      code = 3'd0;
    else if (coeff == REG_SIZE'(1)) code = 3'd1;
    else if (coeff == REG_SIZE'(0)) code = 3'd2;
    else if (coeff == Q_M1)         code = 3'd3;
    else if (coeff == Q_M2)         code = 3'd4;
    else                            err  = 1'b1;
  end

endmodule

// File: rtl/skencode_s1s2_pack.sv
// Packs one s1/s2 polynomial (256 coeffs, 3 bits each) into 24 32-bit words.
// Ports:
//   clk, rst_b (sync, active-low), zeroize (sync clear)
//   start_i                          begin a polynomial (IDLE only)
//   coeff_valid_i/coeff_ready_o/coeff_i   input beats of 4 coeffs, coeff 0 in low bits
//   data_valid_o/data_ready_i/data_o      output words, bit-stream LSB first
//   done_o                           1-cycle pulse after the 24th word is taken
//   error_o                          sticky: an illegal coeff was packed this poly
import skencode_s1s2_pack_pkg::*;

module skencode_s1s2_pack (
  input  logic                          clk,
  input  logic                          rst_b,
  input  logic                          zeroize,
  input  logic                          start_i,
  input  logic                          coeff_valid_i,
  output logic                          coeff_ready_o,
  input  logic [NUM_COEFF*REG_SIZE-1:0] coeff_i,
  output logic                          data_valid_o,
  input  logic                          data_ready_i,
  output logic [DATA_W-1:0]             data_o,
  output logic                          done_o,
  output logic                          error_o
);

  skencode_state_e        state;
  logic [BUF_W-1:0]       pack_buf;
  logic [5:0]             cnt_bits;
  logic [6:0]             in_cnt;
  logic [4:0]             out_cnt;
  logic                   error_q;

  logic [BEAT_BITS-1:0]   beat_code;
  logic [NUM_COEFF-1:0]   beat_err;
  logic                   accept;
  logic                   emit;

  for (genvar k = 0; k < NUM_COEFF; k++) begin : g_enc
    skencode_s1s2_coeff_enc u_enc (
      .coeff (coeff_i[k*REG_SIZE +: REG_SIZE]),
      .code  (beat_code[k*ETA_SIZE +: ETA_SIZE]),
      .err   (beat_err[k])
    );
  end

  // Accept only while fewer than 32 bits are buffered, emit only once 32 are
  // present: the two conditions are mutually exclusive, so the buffer never
  // needs a simultaneous append+shift path. 31 + 12 = 43 bits max fits in 48.
  assign coeff_ready_o = (state == PACK) && (cnt_bits < 6'(DATA_W))
                         && (in_cnt < 7'(NUM_BEATS));
  assign data_valid_o  = (state == PACK) && (cnt_bits >= 6'(DATA_W));
  assign accept        = coeff_valid_i && coeff_ready_o;
  assign emit          = data_valid_o && data_ready_i;

  assign data_o  = data_valid_o ? pack_buf[DATA_W-1:0] : '0;
  assign done_o  = (state == DONE);
  assign error_o = error_q;

  always_ff @(posedge clk) begin
    if (!rst_b || zeroize) begin
      state    <= IDLE;
      pack_buf <= '0;
      cnt_bits <= '0;
      in_cnt   <= '0;
      out_cnt  <= '0;
      error_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state    <= PACK;
            pack_buf <= '0;
            cnt_bits <= '0;
            in_cnt   <= '0;
            out_cnt  <= '0;
            error_q  <= 1'b0;
          end
        end
        PACK: begin
          if (accept) begin
            // Bits above cnt_bits are always zero, so OR-in is an append.
            pack_buf <= pack_buf | (BUF_W'(beat_code) << cnt_bits);
            cnt_bits <= cnt_bits + 6'(BEAT_BITS);
            in_cnt   <= in_cnt + 7'd1;
            if (|beat_err) error_q <= 1'b1;
          end else if (emit) begin
            pack_buf <= pack_buf >> DATA_W;
            cnt_bits <= cnt_bits - 6'(DATA_W);
            out_cnt  <= out_cnt + 5'd1;
            if (out_cnt == 5'(NUM_WORDS - 1)) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_skencode_s1s2_pack.sv
module tb_skencode_s1s2_pack;

  localparam int Q = 8380417;

  logic         clk = 1'b0;
  logic         rst_b;
  logic         zeroize;
  logic         start_i;
  logic         coeff_valid_i;
  logic         coeff_ready_o;
  logic [95:0]  coeff_i;
  logic         data_valid_o;
  logic         data_ready_i;
  logic [31:0]  data_o;
  logic         done_o;
  logic         error_o;

  int errors = 0;
  int checks = 0;
  logic [23:0] coeffs [256];

  always #5 clk = ~clk;

  skencode_s1s2_pack dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .zeroize       (zeroize),
    .start_i       (start_i),
    .coeff_valid_i (coeff_valid_i),
    .coeff_ready_o (coeff_ready_o),
    .coeff_i       (coeff_i),
    .data_valid_o  (data_valid_o),
    .data_ready_i  (data_ready_i),
    .data_o        (data_o),
    .done_o        (done_o),
    .error_o       (error_o)
  );

  // Reference encoding: eta - c taken mod q, illegal values give 0.
  function automatic logic [2:0] model_enc(input logic [23:0] c);
    int v;
    if (c <= 24'd2)            v = 2 - int'(c);
    else if (c >= 24'(Q - 2))  v = 2 + (Q - int'(c));
    else                       v = 0;
    return 3'(v);
  endfunction

  function automatic logic [23:0] rand_legal();
    case ($urandom_range(0, 4))
      0: return 24'd0;
      1: return 24'd1;
      2: return 24'd2;
      3: return 24'(Q - 1);
      default: return 24'(Q - 2);
    endcase
  endfunction

  // Runs one polynomial from coeffs[] with a scoreboard of expected words.
  task automatic run_poly(input string name, input int stall_word, input int stall_len,
                          input int bad_beat, input int pulse_beat);
    logic [767:0] stream;
    logic [31:0]  exp_q [$];
    logic [31:0]  exp_w;
    logic [31:0]  held;
    int beat, words, cyc, stalled, dones;
    bit pulsed;
    stream = '0;
    for (int j = 0; j < 256; j++) stream[3*j +: 3] = model_enc(coeffs[j]);
    for (int w = 0; w < 24; w++) exp_q.push_back(stream[32*w +: 32]);

    @(negedge clk);
    coeff_valid_i = 1'b0;
    data_ready_i  = 1'b1;
    start_i       = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    checks++;
    if (error_o !== 1'b0) begin
      errors++;
      $display("FAIL %s error_clear: got %b want 0", name, error_o);
    end

    beat = 0; words = 0; cyc = 0; stalled = 0; dones = 0; pulsed = 0; held = '0;
    while (words < 24 && cyc < 3000) begin
      if (done_o) dones++;
      if (bad_beat >= 0) begin
        checks++;
        if (error_o !== (beat > bad_beat)) begin
          errors++;
          $display("FAIL %s error_track beat=%0d: got %b want %b", name, beat, error_o, beat > bad_beat);
        end
      end
      start_i = 1'b0;
      if (pulse_beat >= 0 && beat == pulse_beat && !pulsed) begin
        start_i = 1'b1;
        pulsed  = 1;
      end
      coeff_valid_i = (beat < 64) && ($urandom_range(0, 3) != 0);
      if (beat < 64)
        coeff_i = {coeffs[4*beat+3], coeffs[4*beat+2], coeffs[4*beat+1], coeffs[4*beat]};
      if (coeff_valid_i && coeff_ready_o) beat++;

      if (words == stall_word && data_valid_o && stalled < stall_len) begin
        data_ready_i = 1'b0;
        if (stalled == 0) begin
          held = data_o;
          checks++;
          if (data_o !== exp_q[0]) begin
            errors++;
            $display("FAIL %s stall_word: got %h want %h", name, data_o, exp_q[0]);
          end
        end else begin
          checks++;
          if (data_o !== held || data_valid_o !== 1'b1 || coeff_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL %s stall_hold: data %h valid %b ready %b want %h 1 0",
                     name, data_o, data_valid_o, coeff_ready_o, held);
          end
        end
        stalled++;
      end else begin
        data_ready_i = 1'b1;
        if (data_valid_o) begin
          exp_w = exp_q.pop_front();
          checks++;
          if (data_o !== exp_w) begin
            errors++;
            $display("FAIL %s word%0d: got %h want %h", name, words, data_o, exp_w);
          end
          words++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start_i       = 1'b0;
    coeff_valid_i = 1'b0;
    checks++;
    if (words != 24) begin
      errors++;
      $display("FAIL %s timeout: got %0d words want 24", name, words);
    end
    for (int i = 0; i < 4; i++) begin
      if (done_o) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL %s done_pulses: got %0d want 1", name, dones);
    end
    checks++;
    if (data_valid_o !== 1'b0 || coeff_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after: valid %b ready %b want 0 0", name, data_valid_o, coeff_ready_o);
    end
    checks++;
    if (error_o !== (bad_beat >= 0)) begin
      errors++;
      $display("FAIL %s error_final: got %b want %b", name, error_o, bad_beat >= 0);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({coeff_ready_o, data_valid_o, data_o, done_o, error_o} !== '0) begin
      errors++;
      $display("FAIL %s outputs: ready %b valid %b data %h done %b err %b want all 0",
               name, coeff_ready_o, data_valid_o, data_o, done_o, error_o);
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b0; zeroize = 1'b0; start_i = 1'b0;
    coeff_valid_i = 1'b0; data_ready_i = 1'b1; coeff_i = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_b = 1'b1;
    @(negedge clk);
    check_all_zero("reset_released");
  endtask

  task automatic test_all_twos();
    for (int j = 0; j < 256; j++) coeffs[j] = 24'd2;
    run_poly("all_twos", -1, 0, -1, -1);
  endtask

  task automatic test_pattern();
    for (int b = 0; b < 64; b++) begin
      coeffs[4*b]   = 24'd1;
      coeffs[4*b+1] = 24'd0;
      coeffs[4*b+2] = 24'(Q - 1);
      coeffs[4*b+3] = 24'(Q - 2);
    end
    run_poly("pattern", -1, 0, -1, -1);
  endtask

  task automatic test_error();
    for (int j = 0; j < 256; j++) coeffs[j] = rand_legal();
    coeffs[20] = 24'd3;
    run_poly("error", -1, 0, 5, -1);
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 256; j++) coeffs[j] = rand_legal();
    run_poly("back_to_back", -1, 0, -1, -1);
  endtask

  task automatic test_backpressure();
    for (int j = 0; j < 256; j++) coeffs[j] = rand_legal();
    run_poly("backpressure", 7, 50, -1, -1);
  endtask

  task automatic test_reset_mid(input bit use_zeroize);
    int beat, cyc, dones;
    string name;
    name = use_zeroize ? "zeroize_mid" : "reset_mid";
    for (int j = 0; j < 256; j++) coeffs[j] = rand_legal();
    @(negedge clk);
    coeff_valid_i = 1'b0; data_ready_i = 1'b1; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    beat = 0; cyc = 0; dones = 0;
    while (beat < 30 && cyc < 1000) begin
      if (done_o) dones++;
      coeff_valid_i = 1'b1;
      coeff_i = {coeffs[4*beat+3], coeffs[4*beat+2], coeffs[4*beat+1], coeffs[4*beat]};
      if (coeff_ready_o) beat++;
      @(negedge clk);
      cyc++;
    end
    coeff_valid_i = 1'b0;
    if (use_zeroize) zeroize = 1'b1; else rst_b = 1'b0;
    @(negedge clk);
    check_all_zero(name);
    zeroize = 1'b0; rst_b = 1'b1;
    repeat (3) begin
      if (done_o) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones != 0 || beat != 30) begin
      errors++;
      $display("FAIL %s no_done: dones %0d beats %0d want 0 30", name, dones, beat);
    end
    for (int j = 0; j < 256; j++) coeffs[j] = rand_legal();
    run_poly({name, "_fresh"}, -1, 0, -1, -1);
  endtask

  task automatic test_spurious();
    @(negedge clk);
    coeff_valid_i = 1'b1;
    coeff_i = {24'd1, 24'd1, 24'd1, 24'd1};
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (coeff_ready_o !== 1'b0 || data_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL idle_valid: ready %b valid %b want 0 0", coeff_ready_o, data_valid_o);
      end
      @(negedge clk);
    end
    for (int j = 0; j < 256; j++) coeffs[j] = rand_legal();
    run_poly("start_in_pack", -1, 0, -1, 10);
  endtask

  initial begin
    test_reset();
    test_all_twos();
    test_pattern();
    test_error();
    test_back_to_back();
    test_backpressure();
    test_reset_mid(1'b0);
    test_reset_mid(1'b1);
    test_spurious();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
